// File: rtl/input_gpio_loader_if.sv
// Image-memory write port driven by the GPIO pixel loader.
interface input_gpio_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    input mem_we,
    input mem_addr,
    input mem_wdata
  );
endinterface

// File: rtl/input_gpio_loader.sv
// Captures strobed GPIO pixels, packs four per word and
// writes a frame sequentially into image memory.
module input_gpio_loader #(
  parameter int NUM_PIXELS = 160000,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          pixel_in,
  input  logic                strobe_in,
  output logic                ready,
  output logic                done,
  output logic [17:0]         pixel_count,
  input_gpio_loader_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [17:0] LAST_CNT = 18'(NUM_PIXELS - 1);

  logic [1:0]            state;
  logic                  s1, s2, s3;
  logic                  stb_edge;
  logic [1:0]            byte_idx;
  logic [31:0]           pack;
  logic [31:0]           pack_n;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  fin;
  logic                  last_px;

  assign stb_edge = s2 & ~s3;
  assign ready    = (state == LOAD);
  assign done     = (state == DONE);
  assign last_px  = (pixel_count == LAST_CNT);

  always_comb begin
    pack_n = pack;
    pack_n[{byte_idx, 3'b000} +: 8] = pixel_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      byte_idx      <= 2'd0;
      pack          <= '0;
      waddr         <= '0;
      fin           <= 1'b0;
      pixel_count   <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      s1         <= strobe_in;
      s2         <= s1;
      s3         <= s2;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            pixel_count <= '0;
            byte_idx    <= 2'd0;
            waddr       <= '0;
            pack        <= '0;
            fin         <= 1'b0;
          end
        end
        LOAD: begin
          // final word is on the bus this cycle; hand over to DONE
          if (fin) begin
            state <= DONE;
            fin   <= 1'b0;
          end else if (stb_edge) begin
            pixel_count <= pixel_count + 18'd1;
            byte_idx    <= byte_idx + 2'd1;
            if (byte_idx == 2'd3 || last_px) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= waddr;
              bus.mem_wdata <= pack_n;
              waddr         <= waddr + 1'b1;
              pack          <= '0;
              fin           <= last_px;
            end else begin
              pack <= pack_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_gpio_loader.sv
// Randomised bench for input_gpio_loader with a queue-based
// frame packing model.
module tb_input_gpio_loader;

  localparam int NPIX = 10;
  localparam int AW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  pixel_in;
  logic        strobe_in;
  logic        ready;
  logic        done;
  logic [17:0] pixel_count;

  input_gpio_loader_if #(.ADDR_WIDTH(AW)) bus ();

  input_gpio_loader #(
    .NUM_PIXELS(NPIX),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pixel_in   (pixel_in),
    .strobe_in  (strobe_in),
    .ready      (ready),
    .done       (done),
    .pixel_count(pixel_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc = -1;
  logic        done_q = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(int'(bus.mem_addr));
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1 && done_q !== 1'b1) done_cyc = cyc;
    done_q = done;
  end

  logic [7:0] px[$];

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic send_pixel(input logic [7:0] p, input int hi,
                            input int lo, output int raise);
    @(negedge clk);
    pixel_in  = p;
    strobe_in = 1'b1;
    raise     = cyc;
    repeat (hi) @(negedge clk);
    strobe_in = 1'b0;
    pixel_in  = 8'($urandom);
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_range(input int from, input int to);
    int r;
    for (int i = from; i < to; i++)
      send_pixel(px[i], $urandom_range(4, 6), $urandom_range(2, 4), r);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_px(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(8'($urandom_range(1, 255)));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check(tag, done, 1);
  endtask

  // expected words from the pixel list: pixel i -> word i/4, byte i%4
  task automatic check_frame(input string tag);
    logic [31:0] w[$];
    for (int i = 0; i < px.size(); i++) begin
      if (i % 4 == 0) w.push_back(32'd0);
      w[i/4] = w[i/4] | (32'(px[i]) << (8 * (i % 4)));
    end
    check({tag, "_nwr"}, wr_addr.size(), w.size());
    for (int j = 0; j < w.size() && j < wr_addr.size(); j++) begin
      check($sformatf("%s_addr%0d", tag, j), wr_addr[j], j);
      check($sformatf("%s_data%0d", tag, j), wr_data[j], w[j]);
    end
  endtask

  initial begin
    int r3;
    int lastw;
    rst       = 1'b1;
    start     = 1'b0;
    strobe_in = 1'b0;
    pixel_in  = 8'd0;

    repeat (2) begin
      @(negedge clk);
      strobe_in = ~strobe_in;
    end
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_count", pixel_count, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    rst       = 1'b0;
    strobe_in = 1'b0;
    repeat (3) @(negedge clk);

    clear_log();
    fill_px(3);
    send_range(0, 3);
    repeat (4) @(negedge clk);
    check("idle_nwr", wr_addr.size(), 0);
    check("idle_count", pixel_count, 0);
    check("idle_ready", ready, 0);

    clear_log();
    fill_px(NPIX);
    px[0] = 8'h11; px[1] = 8'h22; px[2] = 8'h33; px[3] = 8'h44;
    pulse_start();
    check("f1_ready", ready, 1);
    check("f1_count0", pixel_count, 0);
    send_range(0, 3);
    send_pixel(px[3], 5, 3, r3);
    check("f1_lat_nwr", wr_cyc.size(), 1);
    if (wr_cyc.size() > 0) check("f1_latency", wr_cyc[0], r3 + 3);
    send_range(4, NPIX);
    wait_done("f1_done");
    repeat (2) @(negedge clk);
    check_frame("f1");
    check("f1_count", pixel_count, NPIX);
    check("f1_ready_off", ready, 0);
    check("f1_we_idle", bus.mem_we, 0);
    check("f1_addr_hold", bus.mem_addr, (NPIX + 3) / 4 - 1);
    lastw = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -10;
    check("f1_done_cyc", done_cyc, lastw + 1);

    clear_log();
    fill_px(NPIX);
    pulse_start();
    check("f2_done_clr", done, 0);
    check("f2_count0", pixel_count, 0);
    send_range(0, 4);
    send_pixel(px[4], 10, 3, r3);
    check("f2_long_strobe", pixel_count, 5);
    pulse_start();
    check("f2_start_mid_cnt", pixel_count, 5);
    check("f2_start_mid_rdy", ready, 1);
    send_range(5, NPIX);
    wait_done("f2_done");
    repeat (2) @(negedge clk);
    check_frame("f2");
    check("f2_count", pixel_count, NPIX);

    clear_log();
    fill_px(5);
    pulse_start();
    send_range(0, 5);
    repeat (3) @(negedge clk);
    check("ab_nwr", wr_addr.size(), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ab_ready", ready, 0);
    check("ab_done", done, 0);
    check("ab_count", pixel_count, 0);
    check("ab_wdata", bus.mem_wdata, 0);
    check("ab_addr", bus.mem_addr, 0);
    clear_log();
    send_range(0, 2);
    repeat (3) @(negedge clk);
    check("ab_post_nwr", wr_addr.size(), 0);
    check("ab_post_cnt", pixel_count, 0);

    clear_log();
    fill_px(NPIX);
    pulse_start();
    send_range(0, NPIX);
    wait_done("f3_done");
    repeat (2) @(negedge clk);
    check_frame("f3");

    @(negedge clk);
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check("rs_ready", ready, 0);
    check("rs_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/input_gpio_loader.md
Name: input_gpio_loader

Overview:
Inbound counterpart of the pixel output GPIO path. An external host presents 8-bit pixels on GPIO pins with a strobe. The block synchronises the strobe and captures one pixel per strobe rising edge. It packs four pixels into a 32-bit word and writes the words sequentially into image memory from word address 0, until a full frame of NUM_PIXELS has been received.

Parameters:
NUM_PIXELS, 160000, pixels per frame (400x400); must be at least 1
ADDR_WIDTH, 16, word-address width; 2^ADDR_WIDTH must be at least ceil(NUM_PIXELS/4)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins loading a frame
pixel_in  in  8  GPIO pixel data; host holds it stable while strobe_in is high
strobe_in  in  1  asynchronous GPIO strobe; a rising edge means one pixel is valid
ready  out  1  high while in LOAD; tells the host it may strobe
mem_we  out  1  one-cycle memory write enable
mem_addr  out  ADDR_WIDTH  word address for the write
mem_wdata  out  32  packed word; pixel n goes to byte (n mod 4), byte 0 in bits [7:0]
done  out  1  high in DONE until the next start or rst
pixel_count  out  18  pixels captured in the current frame

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE.
  - All outputs 0: ready, mem_we, mem_addr, mem_wdata, done, pixel_count.
  - Synchroniser flops, pack register and byte index cleared.
  - Applies from any state, including mid-frame; a partial word is discarded.
- Strobe synchroniser:
  - strobe_in passes through two flops (s1, s2) plus a history flop s3.
  - edge = s2 & ~s3.
  - pixel_in is sampled on the edge cycle, which is 2 clocks after the rising edge reaches s1. The host must hold pixel_in stable for at least 4 clk after raising strobe.
  - Synchroniser flops run in every state.
  - An edge outside LOAD is ignored: no capture, no count.
- State machine:
  - IDLE: ready=0. start goes to LOAD and clears pixel_count, byte index and word address.
  - LOAD: ready=1. On each edge:
    - pixel_in goes into pack byte [byte_idx].
    - pixel_count increments and byte_idx increments mod 4.
    - If byte_idx was 3, or this is pixel NUM_PIXELS: on the next cycle mem_we=1 for exactly one cycle, with mem_addr = current word address and mem_wdata = pack register. The word address then increments and the pack register clears.
    - A final partial word keeps zeros in its unfilled upper bytes.
    - After the write of the last pixel's word, go to DONE.
  - DONE: ready=0, done=1, pixel_count holds NUM_PIXELS. start goes to LOAD with counters cleared and done=0 in the same cycle.
  - start while in LOAD is ignored.
- Write timing:
  - Write latency is 1 clk from the capturing edge cycle.
  - Edges are at least 2 clk apart by construction (s2 must fall and rise again), so a write never collides with a capture.
- Outputs when no write is issued:
  - mem_addr and mem_wdata hold their last values when mem_we=0.
  - mem_we is never high outside LOAD, except for the single final write cycle on the LOAD-to-DONE transition.
- Word address wraps modulo 2^ADDR_WIDTH. With legal parameters it never wraps.
- start and rst in the same cycle: rst wins.

Test Plan:
- Reset: drive rst=1 for 2 cycles with strobe toggling -> all outputs 0, state IDLE, no mem_we.
- Idle strobes: 3 strobes without start -> no mem_we, pixel_count=0, ready=0.
- Basic pack: start, then strobes with pixels 0x11,0x22,0x33,0x44 -> one mem_we pulse 1 clk after the 4th edge, with mem_addr=0 and mem_wdata=0x44332211. Next 4 pixels write to mem_addr=1.
- Partial last word: NUM_PIXELS=6, pixels 1..6 -> writes 0x04030201 at address 0, then 0x00000605 at address 1. done rises the cycle after the last write; pixel_count=6.
- Latency: strobe rising at cycle t -> capture at t+2 (within synchroniser tolerance), mem_we at t+3 for a 4th byte. Strobe held high for 10 clk -> exactly one capture.
- Abort and restart: rst after 5 pixels -> outputs cleared, no further writes. A new start, or a start in DONE, restarts at mem_addr=0 with pixel_count=0; a start issued mid-LOAD changes nothing.
